// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM states, divide-by-zero
// result constants and iteration counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    FIX
  } div_state_t;

  // Divide by zero: every quotient bit takes this value; remainder is the raw dividend.
  localparam logic DBZ_QUOTIENT_FILL = 1'b1;
  localparam logic DBZ_FLAG          = 1'b1;

  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of two values. Used for operand
// magnitudes on the way in and for result sign correction on the way out.
module div_sign_fix
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             neg_a,
  input  logic             neg_b,
  output logic [WIDTH-1:0] y_a,
  output logic [WIDTH-1:0] y_b
);

  assign y_a = neg_a ? ('0 - a) : a;
  assign y_b = neg_b ? ('0 - b) : b;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider for DIV/DIVU: FSM, iteration counter and
// {rem, q} shift register. Optional early-out: SEQ_DIVIDER_EARLY_OUT_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_r, dvs_in_r, dvs_r, rem_r, q_r;
  logic             signed_r, neg_q_r, neg_r_r, dbz_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] res_q_r, res_r_r;
  logic             res_dbz_r;

  logic [WIDTH-1:0] dvd_mag, dvs_mag, fix_q, fix_r;
  logic             dvd_neg, dvs_neg, dvs_zero, early_out, fix_active;
  logic [WIDTH:0]   rem_sh, diff;
  logic             trial_ok;

  assign dvd_neg  = signed_r & dvd_r[WIDTH-1];
  assign dvs_neg  = signed_r & dvs_in_r[WIDTH-1];
  assign dvs_zero = (dvs_in_r == '0);

  div_sign_fix #(.WIDTH(WIDTH)) u_op_fix (
    .a     (dvd_r),
    .b     (dvs_in_r),
    .neg_a (dvd_neg),
    .neg_b (dvs_neg),
    .y_a   (dvd_mag),
    .y_b   (dvs_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
    .a     (q_r),
    .b     (rem_r),
    .neg_a (neg_q_r),
    .neg_b (neg_r_r),
    .y_a   (fix_q),
    .y_b   (fix_r)
  );

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  assign early_out = (dvd_mag < dvs_mag);
`else
  assign early_out = 1'b0;
`endif

  // A carry out of the shift means rem_sh >= divisor regardless of the
  // subtraction borrow; the low WIDTH bits of diff are then still exact.
  assign rem_sh   = {rem_r, q_r[WIDTH-1]};
  assign diff     = {1'b0, rem_sh[WIDTH-1:0]} - {1'b0, dvs_r};
  assign trial_ok = rem_sh[WIDTH] | ~diff[WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = LOAD;
      LOAD: begin
        if (flush)                       state_nxt = IDLE;
        else if (dvs_zero || early_out)  state_nxt = FIX;
        else                             state_nxt = CALC;
      end
      CALC: begin
        if (flush)                   state_nxt = IDLE;
        else if (cnt_r == LAST_ITER) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are presented combinationally during FIX so they appear with
  // done, and a flush in FIX can still suppress both.
  always_comb begin
    fix_active  = (state == FIX) && !flush;
    busy        = (state != IDLE);
    done        = fix_active;
    quotient    = res_q_r;
    remainder   = res_r_r;
    div_by_zero = res_dbz_r;
    if (fix_active) begin
      quotient    = dbz_r ? {WIDTH{DBZ_QUOTIENT_FILL}} : fix_q;
      remainder   = dbz_r ? dvd_r : fix_r;
      div_by_zero = dbz_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res_q_r   <= '0;
      res_r_r   <= '0;
      res_dbz_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fix_active) begin
        res_q_r   <= quotient;
        res_r_r   <= remainder;
        res_dbz_r <= div_by_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r    <= '0;
      dvs_in_r <= '0;
      signed_r <= 1'b0;
      dvs_r    <= '0;
      rem_r    <= '0;
      q_r      <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dbz_r    <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r    <= dividend;
            dvs_in_r <= divisor;
            signed_r <= signed_op;
          end
        end
        LOAD: begin
          rem_r   <= early_out ? dvd_mag : '0;
          q_r     <= early_out ? '0 : dvd_mag;
          dvs_r   <= dvs_mag;
          neg_q_r <= dvd_neg ^ dvs_neg;
          neg_r_r <= dvd_neg;
          dbz_r   <= dvs_zero ? DBZ_FLAG : 1'b0;
          cnt_r   <= '0;
        end
        CALC: begin
          rem_r <= trial_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], trial_ok};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
